// File: rtl/clock_enable_reset_gen.sv
// ----------------------------------------------------------------------------
// clock_enable_reset_gen
//
// Purpose: brings the core out of reset once the PLL lock flag has been stable
// for HOLD_CYCLES refclk cycles, and while running generates single-cycle
// clock enables derived from a free-running 6-bit phase counter.
//
// Parameters:
//   HOLD_CYCLES  cycles of stable lock before reset release (2..65535)
//   SYNC_STAGES  depth of the lock synchronizer (2..4)
//
// Ports:
//   refclk     in   64 MHz PLL clock, all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   locked     in   PLL lock flag, asynchronous to refclk
//   pause      in   synchronous; suppresses the CPU enables ce_4p / ce_4n
//   sys_reset  out  active-high system reset, deasserts synchronously
//   ready      out  high while the sequencer is in RUN (always == !sys_reset)
//   ce_16      out  16 MHz enable, one of every 4 cycles
//   ce_4p      out  4 MHz CPU enable, positive phase
//   ce_4n      out  4 MHz CPU enable, negative phase (8 cycles from ce_4p)
//   ce_1       out  1 MHz CRTC enable, one of every 64 cycles
//
// State table:
//   state         | meaning
//   ST_WAIT_LOCK  | waiting for synchronized lock; hold counter cleared
//   ST_HOLD       | lock seen; counting HOLD_CYCLES of continuous lock
//   ST_RUN        | reset released; phase counter and enables running
// ----------------------------------------------------------------------------
module clock_enable_reset_gen #(
   parameter int unsigned HOLD_CYCLES = 1024,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic refclk,
   input  logic rst,
   input  logic locked,
   input  logic pause,
   output logic sys_reset,
   output logic ready,
   output logic ce_16,
   output logic ce_4p,
   output logic ce_4n,
   output logic ce_1
);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_RUN       = 2'd2
   } state_t;

   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_locked_s;

   state_t      r_state;
   logic [15:0] r_hcnt;
   logic [5:0]  r_phase;
   logic        r_sys_reset;
   logic        r_ready;
   logic        r_ce_16;
   logic        r_ce_4p;
   logic        r_ce_4n;
   logic        r_ce_1;

   // Lock synchronizer: the only place the raw lock flag is sampled.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
      end
   end

   assign w_locked_s = r_sync[SYNC_STAGES-1];

   // Sequencer with registered outputs. sys_reset/ready are written on the
   // same edge as the state change, so they track the state exactly.
   // Enables are only decoded when RUN persists across the edge, which keeps
   // every pulse out of the cycle after RUN is left.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_WAIT_LOCK;
         r_hcnt      <= '0;
         r_phase     <= '0;
         r_sys_reset <= 1'b1;
         r_ready     <= 1'b0;
         r_ce_16     <= 1'b0;
         r_ce_4p     <= 1'b0;
         r_ce_4n     <= 1'b0;
         r_ce_1      <= 1'b0;
      end else begin
         r_ce_16 <= 1'b0;
         r_ce_4p <= 1'b0;
         r_ce_4n <= 1'b0;
         r_ce_1  <= 1'b0;
         case (r_state)
            ST_WAIT_LOCK: begin
               r_hcnt      <= '0;
               r_phase     <= '0;
               r_sys_reset <= 1'b1;
               r_ready     <= 1'b0;
               if (w_locked_s) begin
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               r_phase <= '0;
               if (!w_locked_s) begin
                  r_state     <= ST_WAIT_LOCK;
                  r_hcnt      <= '0;
                  r_sys_reset <= 1'b1;
                  r_ready     <= 1'b0;
               end else if (r_hcnt == HOLD_LAST) begin
                  r_state     <= ST_RUN;
                  r_hcnt      <= '0;
                  r_sys_reset <= 1'b0;
                  r_ready     <= 1'b1;
               end else begin
                  r_hcnt      <= r_hcnt + 16'd1;
                  r_sys_reset <= 1'b1;
                  r_ready     <= 1'b0;
               end
            end
            ST_RUN: begin
               r_hcnt <= '0;
               if (!w_locked_s) begin
                  r_state     <= ST_WAIT_LOCK;
                  r_phase     <= '0;
                  r_sys_reset <= 1'b1;
                  r_ready     <= 1'b0;
               end else begin
                  r_phase     <= r_phase + 6'd1;
                  r_sys_reset <= 1'b0;
                  r_ready     <= 1'b1;
                  r_ce_16     <= (r_phase[1:0] == 2'd3);
                  r_ce_4n     <= (r_phase[3:0] == 4'd7)  && !pause;
                  r_ce_4p     <= (r_phase[3:0] == 4'd15) && !pause;
                  r_ce_1      <= (r_phase == 6'd63);
               end
            end
            default: begin
               r_state     <= ST_WAIT_LOCK;
               r_hcnt      <= '0;
               r_phase     <= '0;
               r_sys_reset <= 1'b1;
               r_ready     <= 1'b0;
            end
         endcase
      end
   end

   assign sys_reset = r_sys_reset;
   assign ready     = r_ready;
   assign ce_16     = r_ce_16;
   assign ce_4p     = r_ce_4p;
   assign ce_4n     = r_ce_4n;
   assign ce_1      = r_ce_1;

endmodule

// File: doc/clock_enable_reset_gen.md
CLOCK_ENABLE_RESET_GEN -- requirements
Module: clock_enable_reset_gen

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1024, giving the number of cycles system reset is held after PLL lock is stable (range 2..65535).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the flop depth of the lock synchronizer (range 2..4).
REQ-003 Port refclk  input  1  is the single block clock, 64 MHz PLL output; all state changes on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-high reset.
REQ-005 Port locked  input  1  is the PLL lock flag, asynchronous to refclk.
REQ-006 Port pause  input  1  is synchronous to refclk; when high, CPU enables are suppressed.
REQ-007 Port sys_reset  output  1  is the active-high, synchronous-deassert system reset for the core.
REQ-008 Port ready  output  1  is high while the FSM is in RUN.
REQ-009 Port ce_16  output  1  is the single-cycle 16 MHz enable (1 of 4 cycles).
REQ-010 Port ce_4p  output  1  is the single-cycle 4 MHz CPU enable, positive phase.
REQ-011 Port ce_4n  output  1  is the single-cycle 4 MHz CPU enable, negative phase (8 cycles from ce_4p).
REQ-012 Port ce_1  output  1  is the single-cycle 1 MHz CRTC enable (1 of 64 cycles).

Function
REQ-013 locked SHALL pass through SYNC_STAGES flops; the result is locked_s (latency SYNC_STAGES cycles); no other logic samples locked directly.
REQ-014 The FSM SHALL have states WAIT_LOCK, HOLD, RUN, plus a 16-bit hold counter hcnt.
REQ-015 WAIT_LOCK: hcnt=0; next state HOLD when locked_s=1, else WAIT_LOCK.
REQ-016 HOLD: hcnt increments each cycle; locked_s=0 -> WAIT_LOCK (hcnt cleared); hcnt==HOLD_CYCLES-1 -> RUN; locked_s=0 takes priority over completion in the same cycle.
REQ-017 RUN: locked_s=0 -> WAIT_LOCK next edge; otherwise remain.
REQ-018 sys_reset SHALL be registered as (state != RUN); ready SHALL be registered as (state == RUN); sys_reset==!ready at all times.
REQ-019 A 6-bit phase counter SHALL be held at 0 outside RUN and increment modulo 64 every RUN cycle; the first RUN cycle (index k=0) has phase 0.
REQ-020 Enables SHALL be registered one cycle after decode from phase: ce_16 when phase[1:0]==3, ce_4n when phase[3:0]==7, ce_4p when phase[3:0]==15, ce_1 when phase==63; all only while in RUN.
REQ-021 Consequently, in RUN cycle index k: ce_16 at k=4,8,12,...; ce_4n at k=8,24,...; ce_4p at k=16,32,...; ce_1 at k=64,128,...
REQ-022 pause=1 on a decode edge SHALL force ce_4p and ce_4n low for that edge; phase, ce_16 and ce_1 are unaffected.
REQ-023 On exit from RUN, all ce_* outputs SHALL be 0 from the next edge onward and phase SHALL be cleared; no partial or extra pulse is emitted.
REQ-024 Each enable SHALL never be high in two consecutive cycles.

Reset
REQ-025 While rst=1, asynchronously: state=WAIT_LOCK, hcnt=0, phase=0, synchronizer flops=0, sys_reset=1, ready=0, all ce_*=0.
REQ-026 After rst deasserts, the block SHALL behave as entering WAIT_LOCK; rst asserted mid-HOLD or mid-RUN SHALL restart the full lock/hold sequence.

Verification
REQ-027 Cold start: rst=1 for 5 cycles, locked=1 held from before rst release, HOLD_CYCLES=16, SYNC_STAGES=2 -> sys_reset falls exactly 2+1+16 cycles after rst release (sync, WAIT_LOCK->HOLD, hold), ready rises same edge.
REQ-028 Enable cadence: in RUN for 256 cycles -> 64 ce_16, 16 ce_4p, 16 ce_4n, 4 ce_1 pulses; ce_4p-to-ce_4n spacing 8 cycles; first ce_16 at k=4.
REQ-029 Lock glitch in HOLD: locked low 3 cycles at hcnt=10 -> returns to WAIT_LOCK, hcnt=0, sys_reset stays 1, full 16-cycle hold restarts after relock.
REQ-030 Lock loss in RUN: locked falls -> sys_reset=1, ready=0 and all ce_*=0 within SYNC_STAGES+2 cycles; relock -> phase restarts at 0, first ce_16 at k=4.
REQ-031 Pause: pause=1 for 40 RUN cycles -> zero ce_4p/ce_4n pulses in that window, ce_16 count 10, ce_1 cadence unchanged.
REQ-032 Async reset mid-RUN: rst pulsed between edges -> sys_reset=1 and all ce_*=0 immediately, before the next refclk edge.
